// File: rtl/imm_enc.sv
// RV32I immediate encoder: scatters an immediate into an I/S/B/U/J instruction word,
// range-checks it and queues the result in a small output FIFO. Optional macro: IMMENC_ERR_ZERO_EN.
module imm_enc #(
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           fmt,
  input  logic [31:0]          base,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;

  logic [31:0] imm_mask;
  logic [31:0] imm_bits;
  logic [31:0] enc_instr;
  logic        enc_err;

  logic [32:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // Range checks reduce to "all bits above the field's sign bit equal the sign bit".
  always_comb begin
    imm_mask = '0;
    imm_bits = '0;
    enc_err  = 1'b0;
    case (fmt)
      FMT_I: begin
        imm_mask = 32'hFFF0_0000;
        imm_bits = {imm[11:0], 20'b0};
        enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_S: begin
        imm_mask = 32'hFE00_0F80;
        imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      FMT_B: begin
        imm_mask = 32'hFE00_0F80;
        imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        enc_err  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      FMT_J: begin
        imm_mask = 32'hFFFF_F000;
        imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        enc_err  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
      FMT_U: begin
        imm_mask = 32'hFFFF_F000;
        imm_bits = {imm[31:12], 12'b0};
        enc_err  = |imm[11:0];
      end
      default: begin
        imm_mask = '0;
        imm_bits = '0;
        enc_err  = 1'b1;
      end
    endcase
`ifdef IMMENC_ERR_ZERO_EN
    if (enc_err) imm_bits = '0;
`else
    imm_bits = imm_bits;
`endif
    enc_instr = (base & ~imm_mask) | imm_bits;
  end

  assign in_ready  = (count != (PTR_W+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr][31:0] : '0;
  assign out_err   = out_valid ? mem[rd_ptr][32] : 1'b0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_err, enc_instr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push && enc_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  // A stalled request must be held unchanged until it is accepted.
  property p_hold_request;
    @(posedge clk) disable iff (!rst_n)
      (in_valid && !in_ready) |=> (in_valid && $stable(fmt) && $stable(base) && $stable(imm));
  endproperty
  a_hold_request: assert property (p_hold_request);

endmodule

// File: tb/tb_imm_enc.sv
// Directed self-checking bench for imm_enc (DEPTH=2, ERR_CNT_W=8).
module tb_imm_enc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = 3'b000;
  logic [31:0] base = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

`ifdef IMMENC_ERR_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  imm_enc #(.DEPTH(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .base(base), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Presents a request and holds it until the DUT accepts it; returns 1 time unit after that edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] b, input logic [31:0] i);
    bit done;
    done = 1'b0;
    fmt = f; base = b; imm = i; in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic bumpErr();
    if (exp_cnt < 255) exp_cnt++;
  endtask

  task automatic sendAndCheck(input string tag, input logic [2:0] f, input logic [31:0] b,
                              input logic [31:0] i, input logic [31:0] exp_instr, input bit exp_err);
    applyStimulus(f, b, i);
    if (exp_err) bumpErr();
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, "_instr"}, out_instr, exp_instr);
    checkOutput({tag, "_err"}, {31'b0, out_err}, {31'b0, exp_err});
    checkOutput({tag, "_cnt"}, {24'b0, err_cnt}, exp_cnt);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #12;
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_instr", out_instr, 32'd0);
    checkOutput("rst_err", {31'b0, out_err}, 32'd0);
    checkOutput("rst_cnt", {24'b0, err_cnt}, 32'd0);
    checkOutput("rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Legal encodings
    sendAndCheck("i_neg1", 3'b000, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0);
    sendAndCheck("b_neg4", 3'b010, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    sendAndCheck("j_800",  3'b011, 32'h0000_006F, 32'h0000_0800, 32'h0010_006F, 1'b0);
    sendAndCheck("u_lui",  3'b100, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0);
    sendAndCheck("s_7ff",  3'b001, 32'h0000_2023, 32'h0000_07FF, 32'h7E00_2FA3, 1'b0);
    sendAndCheck("i_min",  3'b000, 32'h0000_0013, 32'hFFFF_F800, 32'h8000_0013, 1'b0);
    sendAndCheck("b_max",  3'b010, 32'h0000_0063, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0);

    // Error cases
    sendAndCheck("i_ovf", 3'b000, 32'h0000_0013, 32'h0000_0800,
                 ZERO_EN ? 32'h0000_0013 : 32'h8000_0013, 1'b1);
    sendAndCheck("b_odd", 3'b010, 32'h0000_0063, 32'h0000_0003,
                 ZERO_EN ? 32'h0000_0063 : 32'h0000_0163, 1'b1);
    sendAndCheck("fmt6", 3'b110, 32'h1234_5678, 32'h0000_0001, 32'h1234_5678, 1'b1);
    sendAndCheck("j_ovf", 3'b011, 32'h0000_006F, 32'h0010_0000,
                 ZERO_EN ? 32'h0000_006F : 32'h8000_006F, 1'b1);
    sendAndCheck("u_low", 3'b100, 32'h0000_0037, 32'h1234_5001,
                 ZERO_EN ? 32'h0000_0037 : 32'h1234_5037, 1'b1);
    sendAndCheck("s_under", 3'b001, 32'h0000_2023, 32'hFFFF_F7FF,
                 ZERO_EN ? 32'h0000_2023 : 32'h7E00_2FA3, 1'b1);

    // Backpressure: two entries fill the FIFO, the third waits
    out_ready = 1'b0;
    applyStimulus(3'b000, 32'h0000_0013, 32'd1);
    applyStimulus(3'b000, 32'h0000_0013, 32'd2);
    checkOutput("bp_full_ready", {31'b0, in_ready}, 32'd0);
    fmt = 3'b000; base = 32'h0000_0013; imm = 32'd3; in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("bp_hold_instr", out_instr, 32'h0010_0013);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_second", out_instr, 32'h0020_0013);
    checkOutput("bp_ready_again", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_pushpop_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bp_third", out_instr, 32'h0030_0013);
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_drained", {31'b0, out_valid}, 32'd0);

    // Reset while entries are queued
    applyStimulus(3'b111, 32'h0000_0033, 32'd0);
    bumpErr();
    applyStimulus(3'b111, 32'h0000_0033, 32'd0);
    bumpErr();
    checkOutput("mid_queued", {31'b0, out_valid}, 32'd1);
    checkOutput("mid_cnt", {24'b0, err_cnt}, exp_cnt);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid_rst_cnt", {24'b0, err_cnt}, 32'd0);
    checkOutput("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("post_rst_empty", {31'b0, out_valid}, 32'd0);
    sendAndCheck("post_rst_i", 3'b000, 32'h0000_0013, 32'd7, 32'h0070_0013, 1'b0);

    // Saturation of the error counter
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      applyStimulus(3'b101, 32'(k), 32'd0);
      bumpErr();
      if (k == 9) checkOutput("sat_cnt10", {24'b0, err_cnt}, exp_cnt);
    end
    checkOutput("sat_cnt", {24'b0, err_cnt}, 32'h0000_00FF);
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("sat_drained", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_enc.md
Name: imm_enc

Overview:
- Immediate encoder for the rv32i datapath: scatters a 32-bit immediate into the immediate bit positions of an RV32I instruction word for formats I/S/B/U/J.
- Checks that the immediate is representable in the selected format and flags it if not.
- Valid/ready on both sides with a small output FIFO.
- Used by the instruction-build path (loader/self-test generator) that feeds instruction memory.

Parameters:
- DEPTH, 2, output FIFO entries (power of 2, >=2).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted when in_valid&in_ready.
- fmt  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101-111 invalid.
- base  input  32  instruction with opcode/rd/rs1/rs2/funct fields; its immediate bit positions are ignored.
- imm  input  32  immediate, two's complement.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes head when out_valid&out_ready.
- out_instr  output  32  encoded instruction at FIFO head.
- out_err  output  1  head entry failed the range/format check.
- err_cnt  output  ERR_CNT_W  count of accepted erroneous requests, saturating.

Behaviour:
- Reset (async assert, sync-released by design): FIFO empty; out_valid=0, out_instr=0, out_err=0, err_cnt=0, in_ready=1.
- Bit mapping; non-immediate bits come from base:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Range check (err=1 if violated):
  - I/S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - fmt 101-111: always err; out_instr=base unchanged.
- Encoding and check are combinational on the inputs; the result is written into the FIFO on acceptance.
- Latency: an entry accepted in cycle N is visible at out_* in cycle N+1 if the FIFO was empty.
- in_ready = (count != DEPTH). No push when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count is unchanged and order is preserved.
- out_valid = (count != 0). out_instr/out_err hold stable while out_valid&!out_ready.
- Strict FIFO order; pointers wrap modulo DEPTH.
- err_cnt increments on acceptance of an err entry and saturates at all-ones.
- Reset mid-operation: in-flight entries are discarded; nothing is emitted after release until a new acceptance.
- in_valid must stay asserted with stable inputs until accepted (checked by assertion).

Optional Feature:
- IMMENC_ERR_ZERO_EN
- Defined: for err entries in I/S/B/U/J formats, all immediate bit positions are forced to 0.
- Undefined: for err entries, the truncated immediate bits are encoded per the mapping.
- In both cases out_err=1 and err_cnt counts the entry.

Test Plan:
- I: fmt=000, base=0x00000013, imm=0xFFFFFFFF -> out_instr=0xFFF00013, out_err=0, one cycle after acceptance.
- B: fmt=010, base=0x00000063, imm=0xFFFFFFFC -> 0xFE000EE3, err=0.
- J/U/S:
  - J: base=0x0000006F, imm=0x00000800 -> 0x0010006F.
  - U: base=0x00000037, imm=0x12345000 -> 0x12345037.
  - S: base=0x00002023, imm=0x7FF -> 0x7E002FA3.
- Errors:
  - I, base=0x00000013, imm=0x00000800 -> out_err=1, err_cnt=1; out_instr=0x80000013 without the macro, 0x00000013 with it.
  - B, imm=3 -> err.
  - fmt=110 -> err, out_instr=base.
  - 300 consecutive errors with ERR_CNT_W=8 -> err_cnt=0xFF.
- Backpressure: out_ready=0, three back-to-back requests (DEPTH=2) -> in_ready=0 after the 2nd acceptance; out_ready=1 -> all three are emitted in order; a simultaneous push/pop at count=1 keeps out_valid=1.
- Reset: rst_n=0 with 2 entries queued and err_cnt=5 -> immediately out_valid=0, err_cnt=0, in_ready=1; first acceptance after release appears next cycle.
